load_store_unit: RTL and testbench

//  Sits between the CPU execute stage and mainMemory. It turns one CPU

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges the CPU execute stage and main memory. Each CPU load or store
//   becomes a single-cycle memory request. The unit then waits for the memory
//   send pulse and returns sign- or zero-extended load data. Misaligned
//   accesses, illegal sizes and memory timeouts finish with an error
//   completion. All outputs are registered.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   cpu_req/we/funct3         access request, direction, RV32I size code
//   cpu_addr, cpu_wdata       byte address, store data (bits [7:0] = lowest byte)
//   cpu_rdata                 extended load data, valid while cpu_done=1
//   cpu_done, cpu_err         completion pulse, error qualifier
//   cpu_busy                  high whenever an access is in flight
//   mem_request               one-cycle request pulse to memory
//   mem_bhw                   one-hot size (001 byte, 010 half, 100 word)
//   mem_WR_nRD                1 = write, 0 = read
//   mem_ADR, mem_DATA         address and MSB-first write data
//   mem_DATAOUT, mem_send     read data and its completion pulse
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_funct3,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        cpu_busy,
   output logic        mem_request,
   output logic [2:0]  mem_bhw,
   output logic        mem_WR_nRD,
   output logic [31:0] mem_ADR,
   output logic [31:0] mem_DATA,
   input  logic [31:0] mem_DATAOUT,
   input  logic        mem_send
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [31:0]        cpu_rdata_q, cpu_rdata_d;
   logic               cpu_done_q, cpu_done_d;
   logic               cpu_err_q, cpu_err_d;
   logic               cpu_busy_q, cpu_busy_d;
   logic               mem_request_q, mem_request_d;
   logic [2:0]         mem_bhw_q, mem_bhw_d;
   logic               mem_wr_q, mem_wr_d;
   logic [31:0]        mem_adr_q, mem_adr_d;
   logic [31:0]        mem_data_q, mem_data_d;

   logic               illegal, misaligned;

   // Memory expects the lowest-address byte in the most significant lane
   // of the access width.
   function automatic logic [31:0] store_fmt(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'b00:   store_fmt = {24'b0, wd[7:0]};
         2'b01:   store_fmt = {16'b0, wd[7:0], wd[15:8]};
         default: store_fmt = {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
         3'b100:  load_ext = {24'b0, d[7:0]};
         3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
         3'b101:  load_ext = {16'b0, d[15:0]};
         default: load_ext = d;
      endcase
   endfunction

   // Stores have no unsigned variants, so any funct3[2] store is illegal.
   assign illegal    = (cpu_funct3 == 3'b011) || (cpu_funct3[2:1] == 2'b11) ||
                       (cpu_we && cpu_funct3[2]);
   assign misaligned = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                       ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      cnt_d       = '0;
      we_d        = we_q;
      funct3_d    = funct3_q;
      cpu_rdata_d = '0;
      mem_bhw_d   = mem_bhw_q;
      mem_wr_d    = mem_wr_q;
      mem_adr_d   = mem_adr_q;
      mem_data_d  = mem_data_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               we_d       = cpu_we;
               funct3_d   = cpu_funct3;
               mem_wr_d   = cpu_we;
               mem_adr_d  = cpu_addr;
               mem_data_d = cpu_we ? store_fmt(cpu_funct3[1:0], cpu_wdata) : 32'b0;
               case (cpu_funct3[1:0])
                  2'b00:   mem_bhw_d = 3'b001;
                  2'b01:   mem_bhw_d = 3'b010;
                  default: mem_bhw_d = 3'b100;
               endcase
               state_d = (illegal || misaligned) ? S_ERR : S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // A send in the final timeout cycle still completes normally.
            if (mem_send) begin
               state_d     = S_DONE;
               cpu_rdata_d = we_q ? 32'b0 : load_ext(funct3_q, mem_DATAOUT);
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Memory-side outputs exist only while an access is issued or pending;
      // this also keeps illegal/misaligned accesses off the memory bus.
      if (!(state_d == S_ISSUE || state_d == S_WAIT)) begin
         mem_bhw_d  = '0;
         mem_wr_d   = 1'b0;
         mem_adr_d  = '0;
         mem_data_d = '0;
      end

      mem_request_d = (state_d == S_ISSUE);
      cpu_done_d    = (state_d == S_DONE) || (state_d == S_ERR);
      cpu_err_d     = (state_d == S_ERR);
      cpu_busy_d    = (state_d != S_IDLE);
   end

   // NOTE: every register, datapath included, is reset so all outputs read 0 immediately on nRST.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         we_q          <= 1'b0;
         funct3_q      <= '0;
         cpu_rdata_q   <= '0;
         cpu_done_q    <= 1'b0;
         cpu_err_q     <= 1'b0;
         cpu_busy_q    <= 1'b0;
         mem_request_q <= 1'b0;
         mem_bhw_q     <= '0;
         mem_wr_q      <= 1'b0;
         mem_adr_q     <= '0;
         mem_data_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         we_q          <= we_d;
         funct3_q      <= funct3_d;
         cpu_rdata_q   <= cpu_rdata_d;
         cpu_done_q    <= cpu_done_d;
         cpu_err_q     <= cpu_err_d;
         cpu_busy_q    <= cpu_busy_d;
         mem_request_q <= mem_request_d;
         mem_bhw_q     <= mem_bhw_d;
         mem_wr_q      <= mem_wr_d;
         mem_adr_q     <= mem_adr_d;
         mem_data_q    <= mem_data_d;
      end
   end

   assign cpu_rdata   = cpu_rdata_q;
   assign cpu_done    = cpu_done_q;
   assign cpu_err     = cpu_err_q;
   assign cpu_busy    = cpu_busy_q;
   assign mem_request = mem_request_q;
   assign mem_bhw     = mem_bhw_q;
   assign mem_WR_nRD  = mem_wr_q;
   assign mem_ADR     = mem_adr_q;
   assign mem_DATA    = mem_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit: loads of every size with extension,
//   stores with byte reordering, misaligned/illegal errors, timeout and
//   last-cycle send, mid-access reset and back-to-back accesses.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        cpu_req;
   logic        cpu_we;
   logic [2:0]  cpu_funct3;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_err;
   logic        cpu_busy;
   logic        mem_request;
   logic [2:0]  mem_bhw;
   logic        mem_WR_nRD;
   logic [31:0] mem_ADR;
   logic [31:0] mem_DATA;
   logic [31:0] mem_DATAOUT;
   logic        mem_send;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.TIMEOUT(16)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_funct3  (cpu_funct3),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_done    (cpu_done),
      .cpu_err     (cpu_err),
      .cpu_busy    (cpu_busy),
      .mem_request (mem_request),
      .mem_bhw     (mem_bhw),
      .mem_WR_nRD  (mem_WR_nRD),
      .mem_ADR     (mem_ADR),
      .mem_DATA    (mem_DATA),
      .mem_DATAOUT (mem_DATAOUT),
      .mem_send    (mem_send)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rdata"}, cpu_rdata, 32'h0);
      check({tag, " done"},  32'(cpu_done), 32'h0);
      check({tag, " err"},   32'(cpu_err), 32'h0);
      check({tag, " busy"},  32'(cpu_busy), 32'h0);
      check({tag, " req"},   32'(mem_request), 32'h0);
      check({tag, " bhw"},   32'(mem_bhw), 32'h0);
      check({tag, " wr"},    32'(mem_WR_nRD), 32'h0);
      check({tag, " adr"},   mem_ADR, 32'h0);
      check({tag, " data"},  mem_DATA, 32'h0);
   endtask

   // Legal access: request, hold in WAIT for wait_cycles, then one send pulse.
   task automatic access_ok(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int wait_cycles, input logic [31:0] dout,
                            input logic [2:0] exp_bhw, input logic [31:0] exp_data,
                            input logic [31:0] exp_rdata);
      cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wdata;
      tick();
      cpu_req = 1'b0;
      check({tag, " issue req"},  32'(mem_request), 32'h1);
      check({tag, " issue bhw"},  32'(mem_bhw), 32'(exp_bhw));
      check({tag, " issue wr"},   32'(mem_WR_nRD), 32'(we));
      check({tag, " issue adr"},  mem_ADR, addr);
      check({tag, " issue data"}, mem_DATA, exp_data);
      check({tag, " issue busy"}, 32'(cpu_busy), 32'h1);
      tick();
      check({tag, " wait req"},   32'(mem_request), 32'h0);
      check({tag, " wait bhw"},   32'(mem_bhw), 32'(exp_bhw));
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         check({tag, " wait done"}, 32'(cpu_done), 32'h0);
      end
      mem_send = 1'b1; mem_DATAOUT = dout;
      tick();
      mem_send = 1'b0; mem_DATAOUT = 32'h0;
      check({tag, " done"},  32'(cpu_done), 32'h1);
      check({tag, " err"},   32'(cpu_err), 32'h0);
      check({tag, " rdata"}, cpu_rdata, exp_rdata);
      check({tag, " busy"},  32'(cpu_busy), 32'h1);
      tick();
      check({tag, " post done"},  32'(cpu_done), 32'h0);
      check({tag, " post busy"},  32'(cpu_busy), 32'h0);
      check({tag, " post rdata"}, cpu_rdata, 32'h0);
   endtask

   // Access rejected before reaching memory.
   task automatic access_err(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
      cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = 32'hFFFF_FFFF;
      tick();
      cpu_req = 1'b0;
      check({tag, " req"},   32'(mem_request), 32'h0);
      check({tag, " done"},  32'(cpu_done), 32'h1);
      check({tag, " err"},   32'(cpu_err), 32'h1);
      check({tag, " rdata"}, cpu_rdata, 32'h0);
      tick();
      check({tag, " post done"}, 32'(cpu_done), 32'h0);
      check({tag, " post busy"}, 32'(cpu_busy), 32'h0);
      check({tag, " post req"},  32'(mem_request), 32'h0);
   endtask

   initial begin
      nRST = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b000;
      cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_DATAOUT = 32'h0; mem_send = 1'b0;
      #3;
      check_all_zero("reset");
      tick();
      nRST = 1'b1;
      tick();

      // Loads of every size, back to back.
      access_ok("LW",  1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 3'b100, 32'h0, 32'hDEAD_BEEF);
      access_ok("LB",  1'b0, 3'b000, 32'h03, 32'h0, 1, 32'h0000_0080, 3'b001, 32'h0, 32'hFFFF_FF80);
      access_ok("LBU", 1'b0, 3'b100, 32'h03, 32'h0, 2, 32'h0000_0080, 3'b001, 32'h0, 32'h0000_0080);
      access_ok("LH",  1'b0, 3'b001, 32'h02, 32'h0, 0, 32'h0000_8001, 3'b010, 32'h0, 32'hFFFF_8001);
      access_ok("LHU", 1'b0, 3'b101, 32'h02, 32'h0, 0, 32'h0000_8001, 3'b010, 32'h0, 32'h0000_8001);

      // Stores: byte reordering, rdata stays 0 whatever memory returns.
      access_ok("SW", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, 32'hFFFF_FFFF, 3'b100, 32'h4433_2211, 32'h0);
      access_ok("SH", 1'b1, 3'b001, 32'h02, 32'h0000_ABCD, 0, 32'h0, 3'b010, 32'h0000_CDAB, 32'h0);

      // Errors: misaligned and illegal encodings.
      access_err("LH mis",  1'b0, 3'b001, 32'h05);
      access_err("LW mis",  1'b0, 3'b010, 32'h22);
      access_err("F3 011",  1'b0, 3'b011, 32'h00);
      access_err("F3 110",  1'b0, 3'b110, 32'h00);
      access_err("SBU ill", 1'b1, 3'b100, 32'h00);

      // mem_send outside WAIT is ignored.
      mem_send = 1'b1; mem_DATAOUT = 32'hFFFF_FFFF;
      tick();
      mem_send = 1'b0; mem_DATAOUT = 32'h0;
      check("idle send done",  32'(cpu_done), 32'h0);
      check("idle send busy",  32'(cpu_busy), 32'h0);
      check("idle send rdata", cpu_rdata, 32'h0);

      // Timeout: 16 WAIT cycles without send; cpu_req while busy is ignored.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h30;
      tick();
      check("to issue req", 32'(mem_request), 32'h1);
      cpu_funct3 = 3'b011;                        // still requesting while busy
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         check("to wait done", 32'(cpu_done), 32'h0);
         check("to wait req",  32'(mem_request), 32'h0);
      end
      check("to wait adr", mem_ADR, 32'h30);
      cpu_req = 1'b0;
      tick();
      check("to done",  32'(cpu_done), 32'h1);
      check("to err",   32'(cpu_err), 32'h1);
      check("to rdata", cpu_rdata, 32'h0);
      tick();
      check("to post busy", 32'(cpu_busy), 32'h0);

      // Send in the last timeout cycle wins.
      access_ok("LW last", 1'b0, 3'b010, 32'h40, 32'h0, 15, 32'h1234_5678, 3'b100, 32'h0, 32'h1234_5678);

      // Reset during WAIT aborts asynchronously.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h50;
      tick();
      cpu_req = 1'b0;
      tick();
      check("rst pre busy", 32'(cpu_busy), 32'h1);
      #2 nRST = 1'b0;
      #1;
      check_all_zero("rst async");
      tick();
      check_all_zero("rst held");
      nRST = 1'b1;
      tick();

      // A store after the aborted access completes normally.
      access_ok("SB", 1'b1, 3'b000, 32'h07, 32'hA5A5_A5C3, 2, 32'h1234_5678, 3'b001, 32'h0000_00C3, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
